// File: rtl/apb_node_reg.sv
// apb_node_reg: registered APB demultiplexer. Decodes one upstream APB
// transfer against NB_MASTER inclusive address windows. It then replays the
// transfer as a SETUP/ACCESS pair on the selected downstream port.
// Unmapped addresses are answered with PSLVERR.
// Optional feature: define APB_NODE_TIMEOUT_EN to abort ACCESS phases that
// run longer than TIMEOUT_CYCLES. Without it, ACCESS waits indefinitely and
// timeout_o is tied low.
module apb_node_reg #(
  parameter int unsigned NB_MASTER      = 10,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]  end_addr_i,
  input  logic [APB_ADDR_WIDTH-1:0]                 s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                 s_pwdata_i,
  input  logic                                      s_pwrite_i,
  input  logic                                      s_psel_i,
  input  logic                                      s_penable_i,
  output logic [APB_DATA_WIDTH-1:0]                 s_prdata_o,
  output logic                                      s_pready_o,
  output logic                                      s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]                 m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                 m_pwdata_o,
  output logic                                      m_pwrite_o,
  output logic                                      m_penable_o,
  output logic [NB_MASTER-1:0]                      m_psel_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]  m_prdata_i,
  input  logic [NB_MASTER-1:0]                      m_pready_i,
  input  logic [NB_MASTER-1:0]                      m_pslverr_i,
  output logic                                      timeout_o
);

  localparam int unsigned IW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_node_reg: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                    r_state;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_write;
  logic [IW-1:0]             r_idx;
  logic                      r_dn_act;
  logic [NB_MASTER-1:0]      r_psel;
  logic                      r_penable;
  logic                      r_pready;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_slverr;
  logic                      r_timeout;

  logic                      w_start;
  logic                      w_hit;
  logic [IW-1:0]             w_idx;
  logic                      w_sel_ready;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          w_cnt_last;
  // The next silent ACCESS cycle would make the count reach TIMEOUT_CYCLES.
  assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  assign w_start     = s_psel_i & s_penable_i;
  assign w_sel_ready = m_pready_i[r_idx];

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if (s_paddr_i >= start_addr_i[i] && s_paddr_i <= end_addr_i[i]) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
  end

  // Transfer FSM. Every output is a flop, or a flop gated by a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_dn_act  <= 1'b0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pready  <= 1'b0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= s_paddr_i;
            r_wdata <= s_pwdata_i;
            r_write <= s_pwrite_i;
            if (w_hit) begin
              r_idx    <= w_idx;
              r_psel   <= NB_MASTER'(1) << w_idx;
              r_dn_act <= 1'b1;
`ifdef APB_NODE_TIMEOUT_EN
              r_cnt    <= '0;
`endif
              r_state  <= S_SETUP;
            end else begin
              r_rdata  <= '0;
              r_slverr <= 1'b1;
              r_pready <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // A slave answer in the same cycle as the final count takes priority.
          if (w_sel_ready) begin
            r_rdata   <= m_prdata_i[r_idx];
            r_slverr  <= m_pslverr_i[r_idx];
            r_pready  <= 1'b1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_dn_act  <= 1'b0;
            r_state   <= S_RESP;
          end
`ifdef APB_NODE_TIMEOUT_EN
          else if (w_cnt_last) begin
            r_rdata   <= '0;
            r_slverr  <= 1'b1;
            r_pready  <= 1'b1;
            r_timeout <= 1'b1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_dn_act  <= 1'b0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_pready <= 1'b0;
          r_rdata  <= '0;
          r_slverr <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_prdata_o  = r_rdata;
  assign s_pready_o  = r_pready;
  assign s_pslverr_o = r_slverr;
  assign m_psel_o    = r_psel;
  assign m_penable_o = r_penable;
  assign m_paddr_o   = r_dn_act ? r_addr  : '0;
  assign m_pwdata_o  = r_dn_act ? r_wdata : '0;
  assign m_pwrite_o  = r_dn_act & r_write;

`ifdef APB_NODE_TIMEOUT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_node_reg.sv
// tb_apb_node_reg: directed bench for apb_node_reg. The timeout scenarios are
// built only when APB_NODE_TIMEOUT_EN is defined.
module tb_apb_node_reg;

  localparam int NB = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NB-1:0][31:0]  start_addr;
  logic [NB-1:0][31:0]  end_addr;
  logic [31:0]          s_paddr = '0;
  logic [31:0]          s_pwdata = '0;
  logic                 s_pwrite = 1'b0;
  logic                 s_psel = 1'b0;
  logic                 s_penable = 1'b0;
  logic [31:0]          s_prdata;
  logic                 s_pready;
  logic                 s_pslverr;
  logic [31:0]          m_paddr;
  logic [31:0]          m_pwdata;
  logic                 m_pwrite;
  logic                 m_penable;
  logic [NB-1:0]        m_psel;
  logic [NB-1:0][31:0]  m_prdata;
  logic [NB-1:0]        m_pready;
  logic [NB-1:0]        m_pslverr;
  logic                 timeout;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int acc_cnt = 0;

  apb_node_reg #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pwrite_i(s_pwrite),
    .s_psel_i(s_psel), .s_penable_i(s_penable),
    .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_pwrite_o(m_pwrite),
    .m_penable_o(m_penable), .m_psel_o(m_psel),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Slave model: counts ACCESS cycles and answers once wait_n of them have passed.
  always_ff @(posedge clk) begin
    if (m_penable) acc_cnt <= acc_cnt + 1;
    else           acc_cnt <= 0;
  end

  always_comb begin
    m_pready = '0;
    if (m_penable && acc_cnt == wait_n) m_pready = '1;
  end

  // One upstream transfer. Latency counts edges after the first upstream ACCESS cycle.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                      output int lat, output logic [31:0] rdata, output logic err,
                      output logic [NB-1:0] psel_or, output int psel_cyc,
                      output logic addr_ok, output logic en_first, output int to_cnt);
    bit first;
    lat = -1; rdata = '0; err = 1'b0; psel_or = '0; psel_cyc = 0;
    addr_ok = 1'b1; en_first = 1'b0; to_cnt = 0; first = 1'b1;
    @(posedge clk); #1;
    s_paddr = addr; s_pwdata = wdata; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (timeout) to_cnt++;
      if (m_psel != '0) begin
        psel_or = psel_or | m_psel;
        psel_cyc++;
        if (m_paddr !== addr || m_pwdata !== wdata || m_pwrite !== wr) addr_ok = 1'b0;
        if (first) begin en_first = m_penable; first = 1'b0; end
      end
      if (s_pready) begin
        lat = c; rdata = s_prdata; err = s_pslverr;
        break;
      end
    end
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    if (timeout) to_cnt++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({s_prdata, s_pready, s_pslverr, m_paddr, m_pwdata, m_pwrite, m_penable, m_psel, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pready=%b psel=%b paddr=%h prdata=%h, need all 0",
               s_pready, m_psel, m_paddr, s_prdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_pready !== 1'b0 || m_psel !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: got pready=%b psel=%b, need 0/0", s_pready, m_psel);
    end
  endtask

  task automatic test_write_hit();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    wait_n = 0; m_pslverr = 10'b11_1111_1101;
    xfer(32'h1A10_1004, 32'hCAFE_F00D, 1'b1, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d need 3", lat); end
    checks++; if (po !== 10'b00_0000_0010) begin errors++; $display("FAIL write_psel: got %b need 0000000010", po); end
    checks++; if (pc !== 2) begin errors++; $display("FAIL write_psel_cycles: got %0d need 2", pc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_bus_fields: got mismatching paddr/pwdata/pwrite, need 1A101004/CAFEF00D/1"); end
    checks++; if (ef !== 1'b0) begin errors++; $display("FAIL write_setup_penable: got %b need 0", ef); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_pslverr: got %b need 0", er); end
    checks++; if (tc !== 0) begin errors++; $display("FAIL write_timeout: got %0d pulses need 0", tc); end
  endtask

  task automatic test_read_waits();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    wait_n = 5; m_pslverr = 10'b11_1111_0111;
    xfer(32'h1A10_3000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL read_wait_latency: got %0d need 8", lat); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_wait_data: got %h need 12345678", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_wait_pslverr: got %b need 0", er); end
    checks++; if (pc !== 7) begin errors++; $display("FAIL read_wait_psel_cycles: got %0d need 7", pc); end
    checks++; if (tc !== 0) begin errors++; $display("FAIL read_wait_timeout: got %0d need 0", tc); end
    checks++; if (s_prdata !== '0 || s_pslverr !== 1'b0) begin errors++; $display("FAIL read_wait_idle_resp: got %h/%b need 0/0", s_prdata, s_pslverr); end
  endtask

  task automatic test_slave_error();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    wait_n = 0; m_pslverr = 10'b00_0000_1000;
    xfer(32'h1A10_3FFF, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (er !== 1'b1 || rd !== 32'h1234_5678) begin errors++; $display("FAIL slave_error: got err=%b data=%h need 1/12345678", er, rd); end
  endtask

  task automatic test_decode();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    wait_n = 0; m_pslverr = '0;
    xfer(32'h1A20_0000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL miss_latency: got %0d need 1", lat); end
    checks++; if (po !== '0) begin errors++; $display("FAIL miss_psel: got %b need 0", po); end
    checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL miss_resp: got err=%b data=%h need 1/0", er, rd); end
    xfer(32'h1A10_2000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (po !== 10'b00_0000_0100) begin errors++; $display("FAIL overlap_psel: got %b need 0000000100", po); end
    checks++; if (rd !== 32'hD0D0_0002) begin errors++; $display("FAIL overlap_data: got %h need D0D00002", rd); end
    xfer(32'h1A10_1FFF, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (po !== 10'b00_0000_0010) begin errors++; $display("FAIL window_end_incl: got %b need 0000000010", po); end
    xfer(32'h0000_0000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (po !== 10'b10_0000_0000 || er !== 1'b0) begin errors++; $display("FAIL zero_window: got psel=%b err=%b need 1000000000/0", po, er); end
    xfer(32'h0000_0001, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (po !== '0 || er !== 1'b1) begin errors++; $display("FAIL disabled_port: got psel=%b err=%b need 0/1", po, er); end
  endtask

`ifdef APB_NODE_TIMEOUT_EN
  task automatic test_timeout();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    wait_n = 1000; m_pslverr = '0;
    xfer(32'h1A10_1000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 6) begin errors++; $display("FAIL timeout_latency: got %0d need 6", lat); end
    checks++; if (pc !== 5) begin errors++; $display("FAIL timeout_psel_cycles: got %0d need 5", pc); end
    checks++; if (tc !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d need 1", tc); end
    checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL timeout_resp: got err=%b data=%h need 1/0", er, rd); end
    wait_n = 3;
    xfer(32'h1A10_1000, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 6 || tc !== 0 || er !== 1'b0 || rd !== 32'hD0D0_0001) begin
      errors++; $display("FAIL timeout_race: got lat=%0d to=%0d err=%b data=%h need 6/0/0/D0D00001", lat, tc, er, rd);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int lat, pc, tc; logic [31:0] rd; logic er, ok, ef; logic [NB-1:0] po;
    bit seen;
    wait_n = 1000; seen = 0;
    @(posedge clk); #1;
    s_paddr = 32'h1A10_3010; s_pwdata = 32'h5555_AAAA; s_pwrite = 1'b1; s_psel = 1'b1;
    @(posedge clk); #1;
    s_penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (m_penable) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_mid_reach_access: got penable=%b need 1", m_penable); end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({s_prdata, s_pready, s_pslverr, m_paddr, m_pwdata, m_pwrite, m_penable, m_psel} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got psel=%b penable=%b paddr=%h, need all 0", m_psel, m_penable, m_paddr);
    end
    s_psel = 1'b0; s_penable = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (s_pready || m_psel != '0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_no_resp: got activity after reset, need none"); end
    wait_n = 0;
    xfer(32'h1A10_3010, 32'h0, 1'b0, lat, rd, er, po, pc, ok, ef, tc);
    checks++; if (lat !== 3 || rd !== 32'h1234_5678 || er !== 1'b0) begin
      errors++; $display("FAIL reset_mid_recover: got lat=%0d data=%h err=%b need 3/12345678/0", lat, rd, er);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      start_addr[i] = 32'h0000_0001;
      end_addr[i]   = 32'h0000_0000;
      m_prdata[i]   = 32'hD0D0_0000 | 32'(i);
    end
    start_addr[0] = 32'h1A10_0000; end_addr[0] = 32'h1A10_0FFF;
    start_addr[1] = 32'h1A10_1000; end_addr[1] = 32'h1A10_1FFF;
    start_addr[2] = 32'h1A10_2000; end_addr[2] = 32'h1A10_2FFF;
    start_addr[3] = 32'h1A10_3000; end_addr[3] = 32'h1A10_3FFF;
    start_addr[5] = 32'h1A10_2000; end_addr[5] = 32'h1A10_5FFF;
    start_addr[9] = 32'h0000_0000; end_addr[9] = 32'h0000_0000;
    m_prdata[3]   = 32'h1234_5678;
    m_pslverr     = '0;
    test_reset();
    test_write_hit();
    test_read_waits();
    test_slave_error();
    test_decode();
`ifdef APB_NODE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
